seg_scan_arbiter: RTL and testbench
===================================

SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit scan tick (minimum 2).
REQ-002 SHALL have parameter HOLD_FRAMES, default 64, meaning full 4-digit frames per ownership slot (minimum 1).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port reqA  input  1  requester A wants the display.
REQ-006 SHALL have port dataA  input  16  requester A value, four hex nibbles; [3:0] is digit 0.
REQ-007 SHALL have port reqB  input  1  requester B wants the display.
REQ-008 SHALL have port dataB  input  16  requester B value, same layout as dataA.
REQ-009 SHALL have port grant  output  2  one-hot owner: [0] is A, [1] is B, 00 is none.
REQ-010 SHALL have port SevOut  output  7  active-low segments for the selected digit, gfedcba.
REQ-011 SHALL have port Dig  output  4  active-low one-cold digit enable.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted for one cycle when the count equals SCAN_DIV-1.
REQ-013 Digit index (2 bits) SHALL increment on tick, 3->0 wrap; a tick with index 3 is a frame boundary.
REQ-014 Dig SHALL equal ~(1<<index); SevOut/Dig are registered and change the cycle after the tick.
REQ-015 FSM states SHALL be IDLE, OWN_A, OWN_B; state changes only at frame boundaries.
REQ-016 IDLE: grant=00, SevOut=7'h7F (blank), scanning continues.
REQ-017 IDLE at boundary: reqA only -> OWN_A; reqB only -> OWN_B; both -> the requester not marked last-owner; neither -> stay.
REQ-018 OWN_x at boundary: if reqx is low -> other requester's state if it requests, else IDLE.
REQ-019 OWN_x with reqx high SHALL count frames; when HOLD_FRAMES frames are reached and the other requester is high, it moves to the other owner; otherwise it stays and the count restarts.
REQ-020 Frame counter SHALL clear on every ownership change and on entry from IDLE.
REQ-021 Last-owner flag SHALL update on each grant; the reset value favours A.
REQ-022 The owner's data SHALL be latched into a 16-bit display register at each frame boundary (including the grant boundary), giving a tear-free frame.
REQ-023 Selected nibble SHALL be decoded to standard hex glyphs 0-F, active-low (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-024 Leading zeros SHALL blank: digit k (k=3..1) shows 7'h7F if it and all higher nibbles are 0; digit 0 is always shown.
REQ-025 grant SHALL be registered and SHALL change in the same cycle as the first Dig update of the new frame.
REQ-026 Request changes mid-frame SHALL have no effect until the next boundary.

Reset
REQ-027 CLR_n low SHALL immediately force: prescaler 0, index 0, state IDLE, frame count 0, display register 0, last-owner=B (so A wins first tie), grant=00, SevOut=7'h7F, Dig=4'b1110.
REQ-028 Reset asserted mid-frame or mid-slot SHALL abandon ownership, with no residual grant after release.
REQ-029 After release, the first tick SHALL occur SCAN_DIV cycles later.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=0, OWN_A=1, OWN_B=2), the blank constant 7'h7F, and the digit count 4.
REQ-031 One sub-module, hex_seg_decode (4-bit nibble in, 7-bit active-low segments out, combinational), SHALL be instantiated once.

Verification (SCAN_DIV=4, HOLD_FRAMES=2)
REQ-032 Reset, no requests -> Dig cycles 1110,1101,1011,0111 every 4 clocks; SevOut=7F; grant=00.
REQ-033 reqA=1, dataA=16'h00A5 -> grant=01 at next frame; frame shows blank, blank, 7'b0001000 (A), 7'b0010010 (5).
REQ-034 reqA=reqB=1 from IDLE -> grant sequence 01,01(2 frames),10,10,01 alternating every 2 frames.
REQ-035 OWN_A, reqA drops mid-frame, reqB=0 -> grant stays 01 until the boundary, then 00 with a blank display.
REQ-036 dataA changes 16'h1234->16'h5678 mid-frame -> the current frame shows all of 1234; the next frame shows all of 5678.
REQ-037 CLR_n pulsed low during OWN_B -> grant=00, Dig=1110, and SevOut=7F asynchronously; after release reqA+reqB tie -> grant=01.

Source files
------------

// File: rtl/seg_scan_arbiter_pkg.sv
// Shared definitions for the two-requester multiplexed seven-segment arbiter.
package seg_scan_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } state_e;

  localparam logic [6:0]  SegBlank  = 7'h7F;
  localparam int unsigned NumDigits = 4;

  // One-hot grant for a state: [0] is A, [1] is B.
  function automatic logic [1:0] grant_of(state_e s);
    return {s == StOwnB, s == StOwnA};
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low seven-segment glyph (gfedcba), purely combinational.
module hex_seg_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Scans a 4-digit seven-segment display and time-shares it between two requesters,
// switching ownership only on frame boundaries so every frame is tear-free.
module seg_scan_arbiter
  import seg_scan_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic        CLK,
  input  logic        CLR_n,
  input  logic        reqA,
  input  logic [15:0] dataA,
  input  logic        reqB,
  input  logic [15:0] dataB,
  output logic [1:0]  grant,
  output logic [6:0]  SevOut,
  output logic [3:0]  Dig
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(NumDigits);
  localparam int unsigned FrmW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            tick, boundary;
  state_e          state_q, state_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            last_b_q, last_b_d;
  logic [15:0]     disp_q, disp_d;
  logic            slot_done;
  logic [1:0]      grant_q, grant_d;
  logic [6:0]      sev_q, sev_d;
  logic [3:0]      dig_q, dig_d;
  logic [3:0]      nib;
  logic [6:0]      glyph;
  logic            lead_zero;

  assign tick      = (cnt_q == CntW'(SCAN_DIV - 1));
  assign boundary  = tick && (idx_q == IdxW'(NumDigits - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign idx_d     = tick ? idx_q + 1'b1 : idx_q;
  assign slot_done = (frm_q == FrmW'(HOLD_FRAMES - 1));

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q  <= StIdle;
      frm_q    <= '0;
      last_b_q <= 1'b1;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      frm_q    <= frm_d;
      last_b_q <= last_b_d;
      disp_q   <= disp_d;
    end
  end

  // FSM next state; everything is frozen between frame boundaries
  always_comb begin
    state_d  = state_q;
    frm_d    = frm_q;
    last_b_d = last_b_q;
    disp_d   = disp_q;
    if (boundary) begin
      unique case (state_q)
        StIdle: begin
          if (reqA && (!reqB || last_b_q)) state_d = StOwnA;
          else if (reqB)                   state_d = StOwnB;
        end
        StOwnA: begin
          if (!reqA)                  state_d = reqB ? StOwnB : StIdle;
          else if (slot_done && reqB) state_d = StOwnB;
        end
        StOwnB: begin
          if (!reqB)                  state_d = reqA ? StOwnA : StIdle;
          else if (slot_done && reqA) state_d = StOwnA;
        end
        default: state_d = StIdle;
      endcase

      if (state_d != state_q || slot_done) frm_d = '0;
      else if (state_d != StIdle)          frm_d = frm_q + 1'b1;

      if (state_d == StOwnA)      last_b_d = 1'b0;
      else if (state_d == StOwnB) last_b_d = 1'b1;

      unique case (state_d)
        StOwnA:  disp_d = dataA;
        StOwnB:  disp_d = dataB;
        default: disp_d = '0;
      endcase
    end
  end

  assign nib = disp_d[{idx_d, 2'b00} +: 4];

  hex_seg_decode u_dec (
    .nibble (nib),
    .seg    (glyph)
  );

  always_comb begin
    lead_zero = 1'b0;
    case (idx_d)
      2'd3: lead_zero = (disp_d[15:12] == '0);
      2'd2: lead_zero = (disp_d[15:8] == '0);
      2'd1: lead_zero = (disp_d[15:4] == '0);
      default: lead_zero = 1'b0;
    endcase
  end

  // FSM outputs, computed for the digit about to be shown
  always_comb begin
    grant_d = grant_of(state_d);
    dig_d   = ~(4'b0001 << idx_d);
    sev_d   = (state_d == StIdle || lead_zero) ? SegBlank : glyph;
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      grant_q <= 2'b00;
      sev_q   <= SegBlank;
      dig_q   <= 4'b1110;
    end else begin
      grant_q <= grant_d;
      sev_q   <= sev_d;
      dig_q   <= dig_d;
    end
  end

  assign grant  = grant_q;
  assign SevOut = sev_q;
  assign Dig    = dig_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter: directed scenarios plus random requests, checked every cycle
// against a frame-level model driven by the cycle count since reset release.
module tb_seg_scan_arbiter;

  localparam int unsigned SD = 4;
  localparam int unsigned HF = 2;

  logic        CLK   = 1'b0;
  logic        CLR_n = 1'b1;
  logic        reqA  = 1'b0;
  logic        reqB  = 1'b0;
  logic [15:0] dataA = '0;
  logic [15:0] dataB = '0;
  logic [1:0]  grant;
  logic [6:0]  SevOut;
  logic [3:0]  Dig;

  int tests = 0;
  int fails = 0;

  // Model: edges since release, current owner (0 none, 1 A, 2 B), frames held,
  // last owner flag and the latched frame value.
  int unsigned e;
  int          owner;
  int          held;
  bit          last_b;
  logic [15:0] disp;
  logic [6:0]  glyph_tab [16];

  seg_scan_arbiter #(
    .SCAN_DIV    (SD),
    .HOLD_FRAMES (HF)
  ) dut (
    .CLK    (CLK),
    .CLR_n  (CLR_n),
    .reqA   (reqA),
    .dataA  (dataA),
    .reqB   (reqB),
    .dataB  (dataB),
    .grant  (grant),
    .SevOut (SevOut),
    .Dig    (Dig)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    e      = 0;
    owner  = 0;
    held   = 0;
    last_b = 1'b1;
    disp   = '0;
  endtask

  task automatic model_frame(input bit ra, input bit rb, input logic [15:0] da,
                             input logic [15:0] db);
    int prev;
    prev = owner;
    if (owner == 0) begin
      if (ra && rb) owner = last_b ? 1 : 2;
      else if (ra)  owner = 1;
      else if (rb)  owner = 2;
    end else begin
      bit mine, other;
      mine  = (owner == 1) ? ra : rb;
      other = (owner == 1) ? rb : ra;
      if (!mine) begin
        owner = other ? 3 - owner : 0;
      end else begin
        held = held + 1;
        if (held >= int'(HF) && other) owner = 3 - owner;
      end
    end
    if (owner != prev || held >= int'(HF)) held = 0;
    if (owner == 1) last_b = 1'b0;
    if (owner == 2) last_b = 1'b1;
    disp = (owner == 1) ? da : (owner == 2) ? db : 16'h0000;
  endtask

  task automatic check();
    int          digit;
    logic [15:0] sh;
    logic [6:0]  exp_sev;
    logic [3:0]  exp_dig;
    logic [1:0]  exp_grant;
    digit     = int'((e / SD) % 4);
    exp_dig   = ~(4'b0001 << digit);
    exp_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    sh        = disp >> (4 * digit);
    if (owner == 0 || (sh == 16'h0000 && digit != 0)) exp_sev = 7'h7F;
    else exp_sev = glyph_tab[sh[3:0]];
    tests++;
    assert (grant === exp_grant)
    else begin fails++; $error("FAIL grant e=%0d got %b want %b", e, grant, exp_grant); end
    tests++;
    assert (Dig === exp_dig)
    else begin fails++; $error("FAIL dig e=%0d got %b want %b", e, Dig, exp_dig); end
    tests++;
    assert (SevOut === exp_sev)
    else begin fails++; $error("FAIL sevout e=%0d got %b want %b", e, SevOut, exp_sev); end
  endtask

  // Inputs only change at +1 after an edge, so here they still hold the sampled values.
  task automatic step();
    @(posedge CLK);
    e = e + 1;
    if (e % SD == 0 && (e / SD) % 4 == 0) model_frame(reqA, reqB, dataA, dataB);
    #1;
    check();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    CLR_n = 1'b0;
    #1;
    tests++;
    assert (grant === 2'b00)
    else begin fails++; $error("FAIL rst_grant got %b want 00", grant); end
    tests++;
    assert (Dig === 4'b1110)
    else begin fails++; $error("FAIL rst_dig got %b want 1110", Dig); end
    tests++;
    assert (SevOut === 7'h7F)
    else begin fails++; $error("FAIL rst_sevout got %b want 1111111", SevOut); end
    repeat (2) @(posedge CLK);
    #1 CLR_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 4))
      0: v = v & 16'h000F;
      1: v = v & 16'h00FF;
      2: v = v & 16'h0FFF;
      3: v = 16'h0000;
      default: v = v;
    endcase
    return v;
  endfunction

  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
    model_reset();

    #2;
    do_reset();
    steps(40);                     // idle scanning

    dataA = 16'h00A5; reqA = 1'b1; // A alone, leading-zero blanking
    steps(48);
    steps(6);
    reqA = 1'b0;                   // A drops mid-frame, nobody else asks
    steps(30);

    do_reset();                    // tie from reset: A first, then alternate
    dataA = 16'h1234; dataB = 16'h0F0F;
    reqA = 1'b1; reqB = 1'b1;
    steps(16 * 13);

    do_reset();                    // mid-frame data change stays out of the current frame
    reqB = 1'b0; dataA = 16'h1234;
    steps(24);
    dataA = 16'h5678;
    steps(40);

    reqA = 1'b0; reqB = 1'b1; dataB = 16'hBEEF;
    steps(40);
    reqA = 1'b1;
    steps(7);
    do_reset();                    // reset during B ownership, tie afterwards
    steps(40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) reqA = ~reqA;
      if ($urandom_range(0, 39) == 0) reqB = ~reqB;
      if ($urandom_range(0, 29) == 0) dataA = rand_data();
      if ($urandom_range(0, 29) == 0) dataB = rand_data();
      if ($urandom_range(0, 799) == 0) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
